// File: rtl/mips_pkg.sv
// Shared register-file constants and the result FIFO entry type.
package mips_pkg;
  localparam int REG_ADDR_W = 5;
  localparam int DATA_W     = 32;
  localparam int NUM_REGS   = 32;
  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [DATA_W-1:0]     data;
  } rf_entry_t;
endpackage

// File: rtl/rf_result_fifo.sv
// Two-entry {rd, data} FIFO holding multi-cycle results until they win the write port.
module rf_result_fifo
  import mips_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [REG_ADDR_W-1:0] in_rd,
  input  logic [DATA_W-1:0]     in_data,
  output logic                  out_valid,
  output logic [REG_ADDR_W-1:0] out_rd,
  output logic [DATA_W-1:0]     out_data,
  input  logic                  pop
);

  rf_entry_t  mem_q [2];
  rf_entry_t  mem_d [2];
  logic       wr_ptr_q, wr_ptr_d;
  logic       rd_ptr_q, rd_ptr_d;
  logic [1:0] count_q, count_d;
  logic       push, deq;

  // Readiness looks only at the registered count, never at a same-cycle pop.
  assign in_ready  = (count_q != 2'd2);
  assign out_valid = (count_q != 2'd0);
  assign out_rd    = mem_q[rd_ptr_q].rd;
  assign out_data  = mem_q[rd_ptr_q].data;

  always_comb begin
    push     = in_valid & in_ready;
    deq      = pop & out_valid;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = '{rd: in_rd, data: in_data};
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (deq) rd_ptr_d = ~rd_ptr_q;
    case ({push, deq})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/regfile_port_arbiter.sv
// Shares the register file write port between WB and queued multi-cycle results,
// with a starvation bound and a pending-destination scoreboard for decode.
module regfile_port_arbiter
  import mips_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wb_we,
  input  logic [REG_ADDR_W-1:0] wb_rd,
  input  logic [DATA_W-1:0]     wb_data,
  output logic                  wb_hold,
  input  logic                  mc_valid,
  output logic                  mc_ready,
  input  logic [REG_ADDR_W-1:0] mc_rd,
  input  logic [DATA_W-1:0]     mc_data,
  input  logic                  issue_valid,
  input  logic [REG_ADDR_W-1:0] issue_rd,
  input  logic [REG_ADDR_W-1:0] rs,
  input  logic [REG_ADDR_W-1:0] rt,
  output logic                  busy_rs,
  output logic                  busy_rt,
  output logic                  rf_we,
  output logic [REG_ADDR_W-1:0] rf_rd,
  output logic [DATA_W-1:0]     rf_data
);

  localparam logic [2:0] SMAX = 3'(STARVE_MAX);

  logic                  head_valid;
  logic [REG_ADDR_W-1:0] head_rd;
  logic [DATA_W-1:0]     head_data;
  logic                  fifo_in_valid;
  logic                  wb_act, grant_fifo, pop;
  logic [2:0]            starve_q, starve_d;
  logic [NUM_REGS-1:0]   pending_q, pending_d;

  // Writes to $zero are accepted but never occupy a FIFO slot.
  assign fifo_in_valid = mc_valid & (mc_rd != REG_ZERO);

  rf_result_fifo u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (fifo_in_valid),
    .in_ready  (mc_ready),
    .in_rd     (mc_rd),
    .in_data   (mc_data),
    .out_valid (head_valid),
    .out_rd    (head_rd),
    .out_data  (head_data),
    .pop       (pop)
  );

  always_comb begin
    wb_act     = wb_we & (wb_rd != REG_ZERO);
    grant_fifo = head_valid & (~wb_act | (starve_q == SMAX));
    pop        = grant_fifo;
    wb_hold    = grant_fifo & wb_act;
    rf_we      = grant_fifo | wb_act;
    rf_rd      = grant_fifo ? head_rd   : wb_rd;
    rf_data    = grant_fifo ? head_data : wb_data;

    starve_d = starve_q;
    if (!head_valid || pop)     starve_d = 3'd0;
    else if (starve_q != SMAX)  starve_d = starve_q + 3'd1;

    // Clear first so a same-cycle issue to that register keeps it pending.
    pending_d = pending_q;
    if (pop) pending_d[head_rd] = 1'b0;
    if (issue_valid) pending_d[issue_rd] = 1'b1;
    pending_d[0] = 1'b0;
  end

  assign busy_rs = pending_q[rs];
  assign busy_rt = pending_q[rt];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_q  <= 3'd0;
      pending_q <= '0;
    end else begin
      starve_q  <= starve_d;
      pending_q <= pending_d;
    end
  end

endmodule
